// File: rtl/datapath_core.sv
// datapath_core: single-bus register-file datapath driven by a T1..T4 command sequencer.
// Optional feature macro: DATAPATH_CORE_MUL_EN enables signed MUL (op 9); otherwise op 9 is illegal.
module datapath_core #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREGS = 16,
    localparam int unsigned AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    ra,
    input  logic [AW-1:0]    rb,
    input  logic [AW-1:0]    rc,
    input  logic             ba_mode,
    input  logic             ld_en,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] bus_mon
);
    localparam int unsigned SW = $clog2(WIDTH);

    typedef enum logic [2:0] {StIdle, StT1, StT2, StT3, StT4, StDone} state_e;

    state_e             state_q;
    logic [3:0]         op_q;
    logic [AW-1:0]      ra_q, rb_q, rc_q;
    logic               ba_q;
    logic [WIDTH-1:0]   y_q, hi_q, lo_q;
    logic [2*WIDTH-1:0] z_q;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic               busy_q, done_q, err_q;

    logic [WIDTH-1:0]   bus;
    logic [2*WIDTH-1:0] alu;
    logic [SW-1:0]      shamt;
    logic               is_mul, illegal;

`ifdef DATAPATH_CORE_MUL_EN
    assign is_mul  = (op_q == 4'd9);
    assign illegal = (op_q > 4'd9);
`else
    assign is_mul  = 1'b0;
    assign illegal = (op_q >= 4'd9);
`endif

    // Single shared bus; idle and done states drive zero.
    always_comb begin
        bus = '0;
        case (state_q)
            StT1:    bus = (ba_q && rb_q == '0) ? '0 : regs_q[rb_q];
            StT2:    bus = regs_q[rc_q];
            StT3:    bus = z_q[WIDTH-1:0];
            StT4:    bus = z_q[2*WIDTH-1:WIDTH];
            default: bus = '0;
        endcase
    end

    assign shamt = bus[SW-1:0];

    always_comb begin
        alu = '0;
        case (op_q)
            4'd0: alu[WIDTH-1:0] = y_q + bus;
            4'd1: alu[WIDTH-1:0] = y_q - bus;
            4'd2: alu[WIDTH-1:0] = y_q & bus;
            4'd3: alu[WIDTH-1:0] = y_q | bus;
            4'd4: alu[WIDTH-1:0] = y_q << shamt;
            4'd5: alu[WIDTH-1:0] = y_q >> shamt;
            4'd6: alu[WIDTH-1:0] = $signed(y_q) >>> shamt;
            4'd7: alu[WIDTH-1:0] = -y_q;
            4'd8: alu[WIDTH-1:0] = ~y_q;
`ifdef DATAPATH_CORE_MUL_EN
            // Sign-extended operands: low 2*WIDTH bits of the product are the signed result.
            4'd9: alu = {{WIDTH{y_q[WIDTH-1]}}, y_q} * {{WIDTH{bus[WIDTH-1]}}, bus};
`endif
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StIdle;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
            ba_q    <= 1'b0;
            y_q     <= '0;
            z_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (ld_en) begin
                        regs_q[ld_addr] <= ld_data;
                    end else if (start) begin
                        op_q    <= op;
                        ra_q    <= ra;
                        rb_q    <= rb;
                        rc_q    <= rc;
                        ba_q    <= ba_mode;
                        busy_q  <= 1'b1;
                        state_q <= StT1;
                    end
                end
                StT1: begin
                    y_q <= bus;
                    if (illegal) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        state_q <= StT2;
                    end
                end
                StT2: begin
                    z_q     <= alu;
                    state_q <= StT3;
                end
                StT3: begin
                    if (is_mul) begin
                        lo_q    <= bus;
                        state_q <= StT4;
                    end else begin
                        regs_q[ra_q] <= bus;
                        done_q       <= 1'b1;
                        state_q      <= StDone;
                    end
                end
                StT4: begin
                    hi_q    <= bus;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign rd_data = regs_q[rd_addr];
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign bus_mon = bus;

endmodule

// File: tb/tb_datapath_core.sv
// tb_datapath_core: directed and random commands against an arithmetic reference model.
module tb_datapath_core;
    localparam int W  = 32;
    localparam int N  = 16;
    localparam int AW = 4;
`ifdef DATAPATH_CORE_MUL_EN
    localparam bit MulEn = 1'b1;
`else
    localparam bit MulEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr, start, ba_mode, ld_en;
    logic [3:0]    op;
    logic [AW-1:0] ra, rb, rc, ld_addr, rd_addr;
    logic [W-1:0]  ld_data, rd_data, hi, lo, bus_mon;
    logic          busy, done, err;

    int errors = 0;
    int checks = 0;

    logic [W-1:0] m_regs [N];
    logic [W-1:0] m_hi, m_lo;

    always #5 clk = ~clk;

    datapath_core #(.WIDTH(W), .NREGS(N)) dut (
        .clk(clk), .clr(clr), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
        .ba_mode(ba_mode), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
        .hi(hi), .lo(lo), .bus_mon(bus_mon)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [W-1:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        m_regs[a] = d;
    endtask

    task automatic read_reg(input logic [AW-1:0] a, output logic [W-1:0] d);
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic check_state(input string tag);
        for (int i = 0; i < N; i++) begin
            rd_addr = AW'(i);
            #1;
            check_eq($sformatf("%s_R%0d", tag, i), rd_data, m_regs[i]);
        end
        check_eq({tag, "_hi"}, hi, m_hi);
        check_eq({tag, "_lo"}, lo, m_lo);
    endtask

    // Reference ALU: result as a 2*W value straight from the operation definitions.
    function automatic logic [63:0] model_alu(input logic [3:0] o, input logic [W-1:0] y,
                                              input logic [W-1:0] c);
        int unsigned sh = c % W;
        logic [W-1:0] r = '0;
        longint sy, sc;
        case (o)
            0: r = y + c;
            1: r = y - c;
            2: r = y & c;
            3: r = y | c;
            4: r = y << sh;
            5: r = y >> sh;
            6: begin
                r = y >> sh;
                if (y[W-1]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            7: r = 32'd0 - y;
            8: r = y ^ 32'hFFFF_FFFF;
            9: begin
                sy = $signed(y);
                sc = $signed(c);
                return 64'(sy * sc);
            end
            default: r = '0;
        endcase
        return {32'd0, r};
    endfunction

    task automatic run_cmd(input logic [3:0] c_op, input logic [AW-1:0] c_ra,
                           input logic [AW-1:0] c_rb, input logic [AW-1:0] c_rc,
                           input logic c_ba);
        logic [W-1:0] y, c;
        logic [63:0]  z;
        logic         mul, legal;
        int           lat, exp_lat;
        logic [W-1:0] exp_bus [$];

        y     = (c_ba && c_rb == 0) ? '0 : m_regs[c_rb];
        c     = m_regs[c_rc];
        mul   = (c_op == 4'd9) && MulEn;
        legal = (c_op <= 4'd8) || mul;
        z     = model_alu(c_op, y, c);
        if (legal) begin
            exp_bus = '{y, c, z[31:0]};
            if (mul) exp_bus.push_back(z[63:32]);
        end else begin
            exp_bus = '{y};
        end
        exp_bus.push_back('0);
        exp_lat = exp_bus.size();

        start = 1'b1; op = c_op; ra = c_ra; rb = c_rb; rc = c_rc; ba_mode = c_ba; ld_en = 1'b0;
        tick();
        start = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            lat = k;
            if (k <= exp_bus.size()) check_eq($sformatf("bus_op%0d_c%0d", c_op, k), bus_mon,
                                              exp_bus[k-1]);
            check_eq($sformatf("busy_op%0d_c%0d", c_op, k), busy, 1);
            if (done) break;
            // Inputs wander while busy; none of it may reach the running command.
            start = 1'($urandom); op = 4'($urandom); ra = AW'($urandom); rb = AW'($urandom);
            rc = AW'($urandom); ba_mode = 1'($urandom); ld_en = 1'($urandom);
            ld_addr = AW'($urandom); ld_data = $urandom;
            tick();
        end
        check_eq($sformatf("latency_op%0d", c_op), lat, exp_lat);
        check_eq($sformatf("err_op%0d", c_op), err, !legal);
        start = 1'b0; ld_en = 1'b0;
        if (legal && !mul) m_regs[c_ra] = z[31:0];
        if (mul) begin
            m_lo = z[31:0];
            m_hi = z[63:32];
        end
        tick();
        check_eq("idle_busy", busy, 0);
        check_eq("idle_done", done, 0);
        check_eq("idle_bus", bus_mon, 0);
        check_state($sformatf("after_op%0d", c_op));
    endtask

    initial begin
        logic [W-1:0] v;
        clr = 1'b1; start = 1'b0; op = '0; ra = '0; rb = '0; rc = '0; ba_mode = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_hi = '0; m_lo = '0;
        tick(); tick();
        clr = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_bus", bus_mon, 0);
        check_state("rst");

        preload(1, 5); preload(2, 7);
        run_cmd(0, 3, 1, 2, 0);
        read_reg(3, v); check_eq("add_r3", v, 12);

        preload(1, 32'hFFFF_FFFF); preload(2, 1);
        run_cmd(0, 3, 1, 2, 0);
        read_reg(3, v); check_eq("add_wrap_r3", v, 0);
        preload(1, 32'h8000_0000); preload(2, 4);
        run_cmd(6, 3, 1, 2, 0);
        read_reg(3, v); check_eq("shra_r3", v, 32'hF800_0000);

        preload(4, 32'hFFFF_FFFD); preload(5, 6);
        run_cmd(9, 7, 4, 5, 0);
        if (MulEn) begin
            check_eq("mul_lo", lo, 32'hFFFF_FFEE);
            check_eq("mul_hi", hi, 32'hFFFF_FFFF);
        end else begin
            check_eq("mul_off_lo", lo, 0);
        end

        preload(0, 9); preload(1, 2);
        run_cmd(0, 6, 0, 1, 1);
        read_reg(6, v); check_eq("ba_r6", v, 2);
        run_cmd(0, 6, 0, 1, 0);
        read_reg(6, v); check_eq("noba_r6", v, 11);

        run_cmd(12, 3, 1, 2, 0);
        run_cmd(0, 1, 1, 1, 0);

        // Load and start together: load wins, no command begins.
        ld_en = 1'b1; start = 1'b1; ld_addr = 8; ld_data = 32'hA5A5_0001; op = 0;
        tick();
        ld_en = 1'b0; start = 1'b0; m_regs[8] = 32'hA5A5_0001;
        check_eq("ld_start_busy", busy, 0);
        tick();
        check_eq("ld_start_busy2", busy, 0);
        check_state("ld_start");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 2) == 0) preload(AW'($urandom), $urandom);
            run_cmd(4'($urandom_range(0, 15)), AW'($urandom), AW'($urandom), AW'($urandom),
                    1'($urandom));
        end

        // clr during T2 of an ADD aborts it and clears everything.
        preload(1, 5); preload(2, 7);
        start = 1'b1; op = 0; ra = 3; rb = 1; rc = 2; ba_mode = 0;
        tick();
        start = 1'b0;
        tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < N; i++) m_regs[i] = '0;
        m_hi = '0; m_lo = '0;
        check_eq("clr_busy", busy, 0);
        check_eq("clr_done", done, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq($sformatf("clr_nodone_%0d", k), done, 0);
        end
        check_state("clr");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/datapath_core.md
DATAPATH_CORE -- requirements
Module: datapath_core

Interface
REQ-001 SHALL have parameter WIDTH, default 32: register, bus and operand width in bits; minimum 8.
REQ-002 SHALL have parameter NREGS, default 16: general register count, power of two, minimum 4; AW = log2(NREGS).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port clr, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port start, input, 1: command request, sampled only in IDLE.
REQ-006 SHALL have port op, input, 4: operation code.
REQ-007 SHALL have ports ra, rb, rc, input, AW each: destination, first source and second source register indices.
REQ-008 SHALL have port ba_mode, input, 1: when high at start, rb index 0 reads as zero.
REQ-009 SHALL have ports ld_en (1), ld_addr (AW), ld_data (WIDTH), input: external register preload.
REQ-010 SHALL have ports rd_addr, input, AW, and rd_data, output, WIDTH: combinational register read.
REQ-011 SHALL have ports busy, done, err, output, 1 each: in operation, completion pulse, illegal-op pulse.
REQ-012 SHALL have ports hi, lo, bus_mon, output, WIDTH each: HI register, LO register, current bus value.

Function
REQ-013 SHALL latch op, ra, rb, rc and ba_mode when start=1 in IDLE; later input changes do not affect the running command.
REQ-014 SHALL sequence IDLE -> T1 -> T2 -> T3 -> [T4 for MUL only] -> DONE -> IDLE, one cycle per state.
REQ-015 T1: bus = R[rb] (zero if ba_mode and rb=0); Y <= bus.
REQ-016 T2: bus = R[rc]; Z (2*WIDTH) <= ALU(Y, bus).
REQ-017 T3: bus = Z low half; non-MUL: R[ra] <= bus; MUL: LO <= bus.
REQ-018 T4 (MUL only): bus = Z high half; HI <= bus.
REQ-019 DONE: done=1 for exactly one cycle; busy=1 in every state except IDLE.
REQ-020 Ops: 0 ADD, 1 SUB (Y-bus), 2 AND, 3 OR, 4 SHL, 5 SHR logical, 6 SHRA, 7 NEG (-Y), 8 NOT (~Y), 9 MUL signed.
REQ-021 Arithmetic modulo 2^WIDTH; Z high half zero for all ops except MUL; shift amount = low log2(WIDTH) bits of bus.
REQ-022 NEG and NOT SHALL still execute T2; the rc value is ignored.
REQ-023 Ops 10-15 illegal: state runs T1 -> DONE, no register, HI or LO write; err=1 together with done.
REQ-024 start while busy SHALL be ignored; no queuing.
REQ-025 ld_en in IDLE SHALL write ld_data to R[ld_addr] at the edge; ignored while busy.
REQ-026 ld_en and start both high in IDLE: load performed, start ignored.
REQ-027 ra equal to rb or rc SHALL be legal; sources are read before the T3 write.
REQ-028 R0 is a real writable register; zeroing applies only to rb reads under ba_mode.
REQ-029 bus_mon SHALL be zero in IDLE and DONE.
REQ-030 rd_data SHALL reflect register contents written at the previous edge.

Reset
REQ-031 clr=1 SHALL, at the edge and from any state, force IDLE and clear all registers, Y, Z, HI, LO, done, err and busy to 0.
REQ-032 clr SHALL have priority over start and ld_en; an interrupted command leaves no partial writes after reset.

Configuration
REQ-033 Macro DATAPATH_CORE_MUL_EN SHALL control MUL: defined gives op 9 as specified; undefined makes op 9 illegal per REQ-023, with no multiplier logic synthesised.

Verification
REQ-034 Preload R1=5, R2=7; ADD ra=3 rb=1 rc=2 -> R3=12, done high in the 4th cycle after start, busy high 4 cycles.
REQ-035 R1=0xFFFFFFFF, R2=1; ADD -> R3=0 (wrap); SHRA with R1=0x80000000, R2=4 -> 0xF8000000.
REQ-036 MUL_EN defined, R4=-3, R5=6; MUL -> LO=0xFFFFFFEE, HI=0xFFFFFFFF, done in 5th cycle; undefined -> err=1, HI and LO unchanged.
REQ-037 R0=9, R1=2, ba_mode=1, ADD ra=6 rb=0 rc=1 -> R6=2; ba_mode=0 -> R6=11.
REQ-038 op=12 -> err=1 and done=1 in the 2nd cycle after start, all registers unchanged; start in the T2 cycle ignored.
REQ-039 clr asserted in T2 of ADD -> next cycle IDLE, R3=0, busy=0, done never pulses.
